// File: rtl/io_manager_pkg.sv
// Shared constants for the memory-mapped I/O manager: register offsets,
// interrupt bit indexes, SRAM strobe bit positions and edge-detector modes.
package io_pkg;

    localparam logic [3:0] OFF_SW   = 4'd0;
    localparam logic [3:0] OFF_BTN  = 4'd1;
    localparam logic [3:0] OFF_LEDR = 4'd2;
    localparam logic [3:0] OFF_LEDG = 4'd3;
    localparam logic [3:0] OFF_PEND = 4'd4;
    localparam logic [3:0] OFF_MASK = 4'd5;

    localparam int unsigned IRQ_BTN0 = 0;
    localparam int unsigned IRQ_BTN1 = 1;
    localparam int unsigned IRQ_BTN2 = 2;
    localparam int unsigned IRQ_BTN3 = 3;
    localparam int unsigned IRQ_SW   = 4;

    // control_mem = {CE_N, OE_N, WE_N, UB_N, LB_N}
    localparam int unsigned CM_CE = 4;
    localparam int unsigned CM_OE = 3;
    localparam int unsigned CM_WE = 2;
    localparam int unsigned CM_UB = 1;
    localparam int unsigned CM_LB = 0;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_ANY
    } edge_mode_e;

endpackage

// File: rtl/io_manager_if.sv
// CPU-side address/strobe bus seen by the I/O manager.
interface io_manager_if;
    logic        oe;
    logic [17:0] addresses;

    modport master (output oe, output addresses);
    modport slave  (input  oe, input  addresses);
endinterface

// File: rtl/io_manager_edge_sync.sv
// Multi-stage input synchronizer with optional edge detector on the synced level.
module io_edge_sync
    import io_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2,
    parameter edge_mode_e  MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign level = chain[STAGES-1];

    // EDGE_NONE drops the previous-value flop entirely.
    generate
        if (MODE == EDGE_NONE) begin : g_none
            assign edge_pulse = '0;
        end else begin : g_edge
            logic [WIDTH-1:0] prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) prev <= '0;
                else        prev <= level;
            end

            if (MODE == EDGE_ANY) begin : g_any
                assign edge_pulse = level ^ prev;
            end else begin : g_rise
                assign edge_pulse = level & ~prev;
            end
        end
    endgenerate

endmodule

// File: rtl/io_manager.sv
// Memory-mapped I/O and SRAM bus manager. Define IO_SWITCH_IRQ_EN to raise
// pending[4] on any change of the synchronized switches.
module io_manager
    import io_pkg::*;
#(
    parameter logic [15:0] IO_BASE     = 16'hFFF0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  MASK_RESET  = 8'h1F
) (
    input  logic         clk,
    input  logic         reset,
    io_manager_if.slave  bus,
    input  logic [3:0]   buttons,
    input  logic [9:0]   switches,
    output logic [9:0]   led_r,
    output logic [7:0]   led_g,
    output logic [4:0]   control_mem,
    output logic [7:0]   interruptions_io,
    inout  wire  [15:0]  data_cpu,
    inout  wire  [15:0]  data_mem
);

`ifdef IO_SWITCH_IRQ_EN
    localparam edge_mode_e SW_MODE = EDGE_ANY;
`else
    localparam edge_mode_e SW_MODE = EDGE_NONE;
`endif

    logic        io_sel;
    logic        io_we;
    logic [3:0]  offset;
    logic [3:0]  btn_level, btn_rise;
    logic [9:0]  sw_level, sw_pulse;
    logic [4:0]  pend_q, pend_set, pend_clr;
    logic [7:0]  mask_q, pending;
    logic [15:0] rd_data;

    assign io_sel = (bus.addresses[15:4] == IO_BASE[15:4]);
    assign io_we  = io_sel & bus.oe;
    assign offset = bus.addresses[3:0];

    io_edge_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .MODE(EDGE_RISE)) u_btn_sync (
        .clk        (clk),
        .rst_n      (reset),
        .din        (buttons),
        .level      (btn_level),
        .edge_pulse (btn_rise)
    );

    io_edge_sync #(.WIDTH(10), .STAGES(SYNC_STAGES), .MODE(SW_MODE)) u_sw_sync (
        .clk        (clk),
        .rst_n      (reset),
        .din        (switches),
        .level      (sw_level),
        .edge_pulse (sw_pulse)
    );

    // Set has priority over write-1-to-clear in the same cycle.
    assign pend_set = {|sw_pulse, btn_rise};
    assign pend_clr = (io_we && offset == OFF_PEND) ? data_cpu[4:0] : '0;
    assign pending  = {3'b000, pend_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r  <= '0;
            led_g  <= '0;
            pend_q <= '0;
            mask_q <= MASK_RESET;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            if (io_we) begin
                case (offset)
                    OFF_LEDR: led_r  <= data_cpu[9:0];
                    OFF_LEDG: led_g  <= data_cpu[7:0];
                    OFF_MASK: mask_q <= data_cpu[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign interruptions_io = pending & mask_q;

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_SW:   rd_data = {6'b0, sw_level};
            OFF_BTN:  rd_data = {12'b0, btn_level};
            OFF_LEDR: rd_data = {6'b0, led_r};
            OFF_LEDG: rd_data = {8'b0, led_g};
            OFF_PEND: rd_data = {8'b0, pending};
            OFF_MASK: rd_data = {8'b0, mask_q};
            default:  rd_data = '0;
        endcase
    end

    // WE_N pulses only in the clk-low half so the address settles first.
    always_comb begin
        control_mem = '1;
        if (!io_sel) begin
            control_mem[CM_CE] = 1'b0;
            control_mem[CM_OE] = bus.oe;
            control_mem[CM_WE] = ~(bus.oe & ~clk);
            control_mem[CM_UB] = 1'b0;
            control_mem[CM_LB] = 1'b0;
        end
    end

    assign data_cpu = bus.oe ? 16'bz : (io_sel ? rd_data : data_mem);
    assign data_mem = (bus.oe && !io_sel) ? data_cpu : 16'bz;

endmodule

// File: tb/tb_io_manager.sv
// Directed self-checking bench for io_manager (register map, IRQs, SRAM strobes).
module tb_io_manager;
    import io_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] buttons;
    logic [9:0] switches;
    logic [9:0] led_r;
    logic [7:0] led_g;
    logic [4:0] control_mem;
    logic [7:0] interruptions_io;
    wire [15:0] data_cpu;
    wire [15:0] data_mem;

    logic        cpu_drv, mem_drv;
    logic [15:0] cpu_val, mem_val;
    logic [15:0] rd;
    int          n_checks;
    int          n_fail;
    int          edges;

    io_manager_if bus ();

    assign data_cpu = cpu_drv ? cpu_val : 16'bz;
    assign data_mem = mem_drv ? mem_val : 16'bz;

    io_manager #(.IO_BASE(16'hFFF0), .SYNC_STAGES(2), .MASK_RESET(8'h1F)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .buttons          (buttons),
        .switches         (switches),
        .led_r            (led_r),
        .led_g            (led_g),
        .control_mem      (control_mem),
        .interruptions_io (interruptions_io),
        .data_cpu         (data_cpu),
        .data_mem         (data_mem)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.addresses = {2'b00, addr};
        cpu_val = data;
        cpu_drv = 1'b1;
        bus.oe  = 1'b1;
        @(posedge clk);
        #1;
        bus.oe  = 1'b0;
        cpu_drv = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        bus.addresses = {2'b00, addr};
        bus.oe = 1'b0;
        #5;
        data = data_cpu;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        buttons  = '0;
        switches = '0;
        cpu_drv  = 1'b0;
        mem_drv  = 1'b0;
        cpu_val  = '0;
        mem_val  = '0;
        bus.oe   = 1'b0;
        bus.addresses = 18'h0FFF0;
        buttons  = 4'b0001;
        wait_cycles(3);
        check("irq_in_reset", interruptions_io, 8'h00);
        buttons  = '0;
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(3);
        check("rst_led_r", led_r, 10'h000);
        check("rst_led_g", led_g, 8'h00);
        check("rst_irq", interruptions_io, 8'h00);
        io_read(16'hFFF5, rd);
        check("rst_mask", rd, 16'h001F);

        // LED registers
        io_write(16'hFFF2, 16'hFFFF);
        io_write(16'hFFF3, 16'h00A5);
        check("led_r", led_r, 10'h3FF);
        check("led_g", led_g, 8'hA5);
        io_read(16'hFFF2, rd);
        check("rd_led_r", rd, 16'h03FF);
        io_read(16'hFFF3, rd);
        check("rd_led_g", rd, 16'h00A5);

        // Short button pulse: exactly three edges to the pending bit
        @(negedge clk);
        buttons = 4'b0001;
        fork
            begin #70; buttons = 4'b0000; end
        join_none
        edges = 0;
        while (interruptions_io == 8'h00 && edges < 6) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("btn0_edges", edges, 3);
        check("btn0_irq", interruptions_io, 8'h01);
        io_read(16'hFFF4, rd);
        check("rd_pend", rd, 16'h0001);

        buttons = 4'b0010;
        wait_cycles(4);
        check("btn1_irq", interruptions_io, 8'h03);

        // Clear and mask
        io_write(16'hFFF4, 16'h0001);
        check("clr_btn0", interruptions_io, 8'h02);
        io_write(16'hFFF4, 16'h0000);
        check("wr0_keeps", interruptions_io, 8'h02);
        io_write(16'hFFF5, 16'h0000);
        check("mask0", interruptions_io, 8'h00);
        io_write(16'hFFF5, 16'h00FF);
        check("mask_ff", interruptions_io, 8'h02);

        // Held button does not retrigger once cleared
        io_write(16'hFFF4, 16'h0002);
        check("clr_btn1", interruptions_io, 8'h00);
        wait_cycles(5);
        check("hold_no_retrig", interruptions_io, 8'h00);

        // Release, re-press, and clear landing on the same edge as the set
        buttons = 4'b0000;
        wait_cycles(4);
        @(negedge clk);
        buttons = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        io_write(16'hFFF4, 16'h0002);
        check("set_beats_clr", interruptions_io, 8'h02);

        // Masked pending stays latched
        io_write(16'hFFF5, 16'h0000);
        buttons = 4'b0110;
        wait_cycles(4);
        check("masked_irq", interruptions_io, 8'h00);
        io_write(16'hFFF5, 16'h00FF);
        check("unmask_irq", interruptions_io, 8'h06);
        io_read(16'hFFF1, rd);
        check("rd_btn", rd, 16'h0006);

        // Unused offsets
        io_write(16'hFFF8, 16'h0000);
        check("unused_wr_led_r", led_r, 10'h3FF);
        io_read(16'hFFF8, rd);
        check("rd_unused", rd, 16'h0000);
        check("cm_io_rd", control_mem, 5'b11111);

        // SRAM read
        mem_val = 16'h1234;
        mem_drv = 1'b1;
        io_read(16'h0010, rd);
        check("sram_rd", rd, 16'h1234);
        check("cm_sram_rd", control_mem, 5'b00100);
        mem_drv = 1'b0;

        // SRAM write: WE_N low only in clk-low half
        @(posedge clk);
        bus.addresses = 18'h00020;
        cpu_val = 16'hBEEF;
        cpu_drv = 1'b1;
        bus.oe  = 1'b1;
        #5;
        check("cm_sram_wr_hi", control_mem, 5'b01100);
        check("sram_wr_data", data_mem, 16'hBEEF);
        @(negedge clk);
        #5;
        check("cm_sram_wr_lo", control_mem, 5'b01000);
        bus.addresses = 18'h0FFF6;
        #1;
        check("cm_io_wr", control_mem, 5'b11111);
        @(posedge clk);
        #1;
        bus.oe  = 1'b0;
        cpu_drv = 1'b0;

        // Switches
        switches = 10'h2AA;
        wait_cycles(4);
        io_read(16'hFFF0, rd);
        check("rd_sw", rd, 16'h02AA);
`ifdef IO_SWITCH_IRQ_EN
        check("sw_irq", interruptions_io, 8'h16);
`else
        check("sw_irq", interruptions_io, 8'h06);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_manager.md
Name: io_manager

Overview:
- Memory-mapped I/O and bus manager between the single-cycle cpu and the board.
- Decodes the cpu address bus and steers the shared cpu data bus to one of two targets:
  - external SRAM (data_mem / control_mem), or
  - internal I/O registers for switches, buttons, red/green LEDs and interrupt status/mask.
- Generates the 8-bit I/O interrupt vector, which is OR-ed with the timer interrupts before it reaches the cpu.

Parameters:
- IO_BASE, 16'hFFF0: base of the 16-word I/O window; addresses[15:4] == IO_BASE[15:4] selects I/O.
- SYNC_STAGES, 2: flip-flop stages on the buttons/switches synchronizers (minimum 2).
- MASK_RESET, 8'h1F: reset value of the interrupt mask register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- oe  input  1  cpu write strobe. 1 = cpu drives data_cpu (write); 0 = cpu reads.
- addresses  input  18  [15:0] cpu word address; [17:16] passed to SRAM (0 when undriven).
- buttons  input  4  push buttons, active-high (1 = pressed).
- switches  input  10  slide switches.
- led_r  output  10  red LED register.
- led_g  output  8  green LED register.
- control_mem  output  5  SRAM strobes {CE_N, OE_N, WE_N, UB_N, LB_N}, all active-low.
- interruptions_io  output  8  pending & mask.
- data_cpu  inout  16  cpu data bus.
- data_mem  inout  16  SRAM data bus.

Behaviour:
- Reset (reset=0, asynchronous): led_r=0, led_g=0, pending=0, mask=MASK_RESET, synchronizer/edge flops=0.
  - While reset is low, interruptions_io=0.
- I/O register map, offset = addresses[3:0]:
  - 0: switches, read-only, zero-extended.
  - 1: buttons, read-only, synchronized, zero-extended.
  - 2: led_r, read/write, bits [9:0].
  - 3: led_g, read/write, bits [7:0].
  - 4: pending, read; write-1-to-clear.
  - 5: mask, read/write.
  - 6..15: read 0; writes ignored.
- Writes: in the I/O window with oe=1, the register updates on the rising clk edge; unused upper data bits are ignored.
- Reads: combinational (zero latency).
  - oe=0: data_cpu is driven with the I/O mux in the I/O window, otherwise with data_mem.
  - oe=1: data_cpu is high-Z.
- SRAM region (any address outside the I/O window):
  - CE_N=0, UB_N=0, LB_N=0.
  - OE_N = oe.
  - WE_N = ~(oe & ~clk): write pulse only in the clk-low half, so the address is stable in the high half.
  - data_mem = data_cpu when oe=1, else high-Z.
- In the I/O window, control_mem = 5'b11111 and data_mem is high-Z.
- Synchronization and edge detection:
  - buttons and switches pass through SYNC_STAGES flops, then a rising-edge detector against a previous-value flop.
  - A high level held at least one clk period produces exactly one edge event.
  - With SYNC_STAGES=2, the pending bit is visible after the 3rd rising edge following the input rise.
- Interrupt sources:
  - pending[i] (i=0..3) sets on a button[i] rising edge.
  - pending[7:5] is hardwired 0.
- Pending is sticky until cleared.
  - Simultaneous set and write-1-clear in the same cycle: set wins, the bit stays 1.
  - Writing 0 leaves the bit unchanged.
- interruptions_io = pending & mask, combinational from registers.
  - A masked pending bit stays latched and appears on the output when it is unmasked.
- Holding a button does not re-trigger; a release and re-press produces a new event.

Optional Feature:
- Macro: IO_SWITCH_IRQ_EN.
- Defined:
  - pending[4] sets on any change (either direction) of the synchronized switches vector, compared to its value one cycle earlier.
  - Its priority and clear rules match the button bits.
- Undefined:
  - pending[4] is hardwired 0 and the switch change-detect flops are not generated.
- The register map is identical in both builds.

Decomposition:
- Package io_pkg holds:
  - I/O offset constants (OFF_SW, OFF_BTN, OFF_LEDR, OFF_LEDG, OFF_PEND, OFF_MASK);
  - interrupt bit indexes (IRQ_BTN0..3, IRQ_SW);
  - control_mem bit positions (CM_CE..CM_LB).
- One sub-module, io_edge_sync: parameterized width and stage count; outputs the synchronized level and a rising-edge pulse. Instantiated once for buttons and once for switches.
- Decode, register file, bus tristates and SRAM strobes live in io_manager.

Test Plan:
- Reset: hold reset=0, then release -> led_r=0, led_g=0, interruptions_io=0, read of 0xFFF5 returns 16'h001F.
- LED write/readback: write 16'h03FF to 0xFFF2 and 16'h00A5 to 0xFFF3 with oe=1 -> led_r=10'h3FF, led_g=8'hA5; reads with oe=0 return 16'h03FF and 16'h00A5.
- Button interrupt:
  - buttons=4'b0001 for 70 ns (clk period 60 ns) -> interruptions_io=8'h01 within 3 edges; read 0xFFF4 returns 16'h0001.
  - Then buttons=4'b0010 -> interruptions_io=8'h03.
- Clear and mask:
  - Write 16'h0001 to 0xFFF4 -> interruptions_io=8'h02.
  - Write 16'h0000 to 0xFFF5 -> 8'h00; write 16'h00FF -> 8'h02 again.
  - Set coinciding with clear keeps the bit set.
- SRAM pass-through:
  - Read 0x0010 with data_mem=16'h1234 -> data_cpu=16'h1234, control_mem=5'b00100 ({CE_N,OE_N,WE_N,UB_N,LB_N}).
  - Write with oe=1 -> data_mem follows data_cpu, WE_N low only while clk is low; in the I/O window control_mem=5'b11111.
- Switch read (and IO_SWITCH_IRQ_EN): switches=10'h2AA -> read 0xFFF0 returns 16'h02AA; with the macro defined, interruptions_io[4]=1.
